// File: rtl/write_operation_if.sv
// Write-port handshake bundle for the 8x32 register file.
// Requester drives the master side; write_operation sits on the slave side.
interface write_operation_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic                  we;
    logic [2:0]            wAddr;
    logic [DATA_W-1:0]     wData;
    logic [DATA_W/8-1:0]   wBe;
    logic                  ready;
    logic                  wr_done;
    logic [2:0]            done_addr;
    logic [PW-1:0]         pending;

    modport master (
        output we, wAddr, wData, wBe,
        input  ready, wr_done, done_addr, pending
    );

    modport slave (
        input  we, wAddr, wData, wBe,
        output ready, wr_done, done_addr, pending
    );
endinterface

// File: rtl/write_operation.sv
// Register-file write port: request FIFO feeding one byte-masked commit per cycle.
// Define REG0_ZERO_EN to hardwire register 0 to zero.
module write_operation #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    write_operation_if.slave  bus,
    output logic [DATA_W-1:0] to_reg0,
    output logic [DATA_W-1:0] to_reg1,
    output logic [DATA_W-1:0] to_reg2,
    output logic [DATA_W-1:0] to_reg3,
    output logic [DATA_W-1:0] to_reg4,
    output logic [DATA_W-1:0] to_reg5,
    output logic [DATA_W-1:0] to_reg6,
    output logic [DATA_W-1:0] to_reg7
);
    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {IDLE, COMMIT} state_t;

    state_t            state;
    logic [2:0]        q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [NB-1:0]     q_be   [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [PW-1:0]     count;
    logic [PW-1:0]     count_nxt;
    logic [DATA_W-1:0] regs [8];
    logic              push;
    logic              pop;
    logic              head_wr;

    assign bus.ready   = (count != PW'(DEPTH));
    assign bus.pending = count;
    assign push        = bus.we && bus.ready;
    assign pop         = (state == COMMIT) && (count != '0);
    assign count_nxt   = count + PW'(push) - PW'(pop);

`ifdef REG0_ZERO_EN
    // Address-0 commits still pulse wr_done but never touch storage.
    assign head_wr = (q_addr[rd_ptr] != 3'd0);
    assign to_reg0 = '0;
`else
    assign head_wr = 1'b1;
    assign to_reg0 = regs[0];
`endif

    assign to_reg1 = regs[1];
    assign to_reg2 = regs[2];
    assign to_reg3 = regs[3];
    assign to_reg4 = regs[4];
    assign to_reg5 = regs[5];
    assign to_reg6 = regs[6];
    assign to_reg7 = regs[7];

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= bus.wAddr;
            q_data[wr_ptr] <= bus.wData;
            q_be[wr_ptr]   <= bus.wBe;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.wr_done   <= 1'b0;
            bus.done_addr <= 3'd0;
            for (int r = 0; r < 8; r++) begin
                regs[r] <= '0;
            end
        end else begin
            count       <= count_nxt;
            state       <= (count_nxt != '0) ? COMMIT : IDLE;
            bus.wr_done <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + AW'(1);
                bus.done_addr <= q_addr[rd_ptr];
                for (int b = 0; b < NB; b++) begin
                    if (q_be[rd_ptr][b] && head_wr) begin
                        regs[q_addr[rd_ptr]][8*b +: 8] <= q_data[rd_ptr][8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_write_operation.sv
// Self-checking bench for write_operation: directed steps plus random traffic
// compared against a queue-and-array reference model.
module tb_write_operation;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int NB     = DATA_W / 8;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] to_reg [8];

    req_t        mq [$];
    logic [31:0] m_reg [8];
    logic        m_done;
    logic [2:0]  m_addr;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    write_operation_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    write_operation #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .to_reg0 (to_reg[0]),
        .to_reg1 (to_reg[1]),
        .to_reg2 (to_reg[2]),
        .to_reg3 (to_reg[3]),
        .to_reg4 (to_reg[4]),
        .to_reg5 (to_reg[5]),
        .to_reg6 (to_reg[6]),
        .to_reg7 (to_reg[7])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int r = 0; r < 8; r++) m_reg[r] = '0;
        m_done = 1'b0;
        m_addr = 3'd0;
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic step(input logic we, input logic [2:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic rst);
        logic acc;
        req_t e;
        bus.we    = we;
        bus.wAddr = a;
        bus.wData = d;
        bus.wBe   = be;
        reset     = rst;
        acc = we && (mq.size() < DEPTH);
        if (!rst) chk("ready", {31'b0, bus.ready}, {31'b0, mq.size() != DEPTH});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_done = 1'b1;
                m_addr = e.a;
`ifdef REG0_ZERO_EN
                if (e.a != 3'd0)
`endif
                for (int b = 0; b < NB; b++)
                    if (e.be[b]) m_reg[e.a][8*b +: 8] = e.d[8*b +: 8];
            end
            if (acc) mq.push_back('{a: a, d: d, be: be});
        end
        @(negedge clk);
        bus.we = 1'b0;
        reset  = 1'b0;
        chk("wr_done", {31'b0, bus.wr_done}, {31'b0, m_done});
        chk("done_addr", {29'b0, bus.done_addr}, {29'b0, m_addr});
        chk("pending", {30'b0, bus.pending}, mq.size());
        for (int r = 0; r < 8; r++)
            chk($sformatf("to_reg%0d", r), to_reg[r], m_reg[r]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 4'd0, 1'b0);
    endtask

    initial begin
        bus.we    = 1'b0;
        bus.wAddr = 3'd0;
        bus.wData = '0;
        bus.wBe   = '0;
        reset     = 1'b1;
        model_reset();
        @(negedge clk);
        step(1'b0, 3'd0, 32'd0, 4'd0, 1'b1);
        chk("rst_ready", {31'b0, bus.ready}, 32'd1);
        chk("rst_pending", {30'b0, bus.pending}, 32'd0);

        // Single full-word write with latency check.
        step(1'b1, 3'd3, 32'hDEADBEEF, 4'hF, 1'b0);
        chk("lat_pre", to_reg[3], 32'd0);
        idle(1);
        chk("t1_reg3", to_reg[3], 32'hDEADBEEF);
        chk("t1_done", {31'b0, bus.wr_done}, 32'd1);
        chk("t1_addr", {29'b0, bus.done_addr}, 32'd3);
        idle(1);
        chk("t1_done_low", {31'b0, bus.wr_done}, 32'd0);

        // Byte-masked merge.
        step(1'b1, 3'd5, 32'h11223344, 4'hF, 1'b0);
        step(1'b1, 3'd5, 32'hAABBCCDD, 4'h5, 1'b0);
        idle(2);
        chk("t2_reg5", to_reg[5], 32'h11BB33DD);

        // Streaming at full throughput.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 3'(i), 32'(i + 1), 4'hF, 1'b0);
            chk("t3_pend_le1", {31'b0, bus.pending <= 1}, 32'd1);
        end
        idle(2);
        for (int i = 1; i < 6; i++) chk("t3_reg", to_reg[i], 32'(i + 1));

        // Zero strobes commit without changing storage.
        step(1'b1, 3'd4, 32'hFFFFFFFF, 4'h0, 1'b0);
        idle(1);
        chk("be0_done", {31'b0, bus.wr_done}, 32'd1);
        chk("be0_reg4", to_reg[4], 32'd5);

        // Register 0 write.
        step(1'b1, 3'd0, 32'hFFFFFFFF, 4'hF, 1'b0);
        idle(1);
        chk("r0_done", {31'b0, bus.wr_done}, 32'd1);
        chk("r0_addr", {29'b0, bus.done_addr}, 32'd0);
`ifdef REG0_ZERO_EN
        chk("r0_val", to_reg[0], 32'd0);
`else
        chk("r0_val", to_reg[0], 32'hFFFFFFFF);
`endif

        // Reset with a queued entry and a same-cycle request.
        step(1'b1, 3'd6, 32'h12345678, 4'hF, 1'b0);
        step(1'b1, 3'd7, 32'h9ABCDEF0, 4'hF, 1'b1);
        chk("mid_rst_pend", {30'b0, bus.pending}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.ready}, 32'd1);
        chk("mid_rst_reg6", to_reg[6], 32'd0);
        idle(2);
        chk("mid_rst_reg7", to_reg[7], 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 32'($urandom), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 59) == 0));
        end
        idle(3);
        chk("end_pending", {30'b0, bus.pending}, 32'd0);
        chk("end_ready", {31'b0, bus.ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
